// File: rtl/alu_issue_if.sv
// Bundle between the alu_issue stage and its environment: instruction source,
// register file read/write ports and the alu execute unit.
interface alu_issue_if #(
  parameter int WIDTH = 32
);
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instr;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic             alu_en;
  logic [4:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_valid;
  logic [WIDTH-1:0] alu_result;
  logic             wb_en;
  logic [4:0]       wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             illegal;

  modport master (
    input  instr_valid, instr, rs1_data, rs2_data, alu_valid, alu_result,
    output instr_ready, rs1_addr, rs2_addr, alu_en, alu_op, alu_a, alu_b,
           wb_en, wb_addr, wb_data, illegal
  );

  modport slave (
    output instr_valid, instr, rs1_data, rs2_data, alu_valid, alu_result,
    input  instr_ready, rs1_addr, rs2_addr, alu_en, alu_op, alu_a, alu_b,
           wb_en, wb_addr, wb_data, illegal
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: one-instruction-in-flight decode / operand fetch / writeback stage
// in front of the alu execute unit. Define M_EXT_EN to decode mul/div/rem.
module alu_issue #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  alu_issue_if.master bus
);

  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b01110;
  localparam logic [4:0] OP_SRL = 5'b01111;
  localparam logic [4:0] OP_SRA = 5'b10000;
  localparam logic [4:0] OP_XOR = 5'b01101;
  localparam logic [4:0] OP_OR  = 5'b01100;
  localparam logic [4:0] OP_AND = 5'b01010;
  localparam logic [4:0] OP_LUI = 5'b11000;
`ifdef M_EXT_EN
  localparam logic [4:0] OP_MUL = 5'b00100;
  localparam logic [4:0] OP_DIV = 5'b01000;
  localparam logic [4:0] OP_REM = 5'b01001;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    WB    = 3'd4,
    ILL   = 3'd5
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [4:0] op;
    logic       use_rs2;
    logic       is_lui;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d = '0;
    case (ins[6:0])
      7'b0110011: begin
        d.use_rs2 = 1'b1;
        case (ins[31:25])
          7'b0000000: begin
            case (ins[14:12])
              3'b000:  {d.legal, d.op} = {1'b1, OP_ADD};
              3'b001:  {d.legal, d.op} = {1'b1, OP_SLL};
              3'b100:  {d.legal, d.op} = {1'b1, OP_XOR};
              3'b101:  {d.legal, d.op} = {1'b1, OP_SRL};
              3'b110:  {d.legal, d.op} = {1'b1, OP_OR};
              3'b111:  {d.legal, d.op} = {1'b1, OP_AND};
              default: {d.legal, d.op} = {1'b0, 5'b00000};
            endcase
          end
          7'b0100000: begin
            case (ins[14:12])
              3'b000:  {d.legal, d.op} = {1'b1, OP_SUB};
              3'b101:  {d.legal, d.op} = {1'b1, OP_SRA};
              default: {d.legal, d.op} = {1'b0, 5'b00000};
            endcase
          end
`ifdef M_EXT_EN
          7'b0000001: begin
            case (ins[14:12])
              3'b000:  {d.legal, d.op} = {1'b1, OP_MUL};
              3'b100:  {d.legal, d.op} = {1'b1, OP_DIV};
              3'b110:  {d.legal, d.op} = {1'b1, OP_REM};
              default: {d.legal, d.op} = {1'b0, 5'b00000};
            endcase
          end
`endif
          default: {d.legal, d.op} = {1'b0, 5'b00000};
        endcase
      end
      7'b0010011: begin
        case (ins[14:12])
          3'b000: {d.legal, d.op} = {1'b1, OP_ADD};
          3'b100: {d.legal, d.op} = {1'b1, OP_XOR};
          3'b110: {d.legal, d.op} = {1'b1, OP_OR};
          3'b111: {d.legal, d.op} = {1'b1, OP_AND};
          3'b001: begin
            if (ins[31:25] == 7'b0000000) begin
              {d.legal, d.op} = {1'b1, OP_SLL};
            end else begin
              {d.legal, d.op} = {1'b0, 5'b00000};
            end
          end
          3'b101: begin
            if (ins[31:25] == 7'b0000000) begin
              {d.legal, d.op} = {1'b1, OP_SRL};
            end else if (ins[31:25] == 7'b0100000) begin
              {d.legal, d.op} = {1'b1, OP_SRA};
            end else begin
              {d.legal, d.op} = {1'b0, 5'b00000};
            end
          end
          default: {d.legal, d.op} = {1'b0, 5'b00000};
        endcase
      end
      7'b0110111: begin
        d.legal  = 1'b1;
        d.op     = OP_LUI;
        d.is_lui = 1'b1;
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  state_t           state_r;
  state_t           state_next;
  dec_t             dec_s;
  logic             accept_s;
  logic [WIDTH-1:0] imm_s;
  logic [4:0]       rs1_addr_s;
  logic [4:0]       rs2_addr_s;

  logic             instr_ready_r;
  logic [4:0]       rs1_addr_r;
  logic [4:0]       rs2_addr_r;
  logic [4:0]       rd_r;
  logic [4:0]       op_r;
  logic             use_rs2_r;
  logic             is_lui_r;
  logic [WIDTH-1:0] imm_r;
  logic             alu_en_r;
  logic [4:0]       alu_op_r;
  logic [WIDTH-1:0] alu_a_r;
  logic [WIDTH-1:0] alu_b_r;
  logic             wb_en_r;
  logic [4:0]       wb_addr_r;
  logic [WIDTH-1:0] wb_data_r;
  logic             illegal_r;

  assign dec_s    = decode(bus.instr);
  assign accept_s = (state_r == IDLE) && bus.instr_valid;

  // Immediate operand of the offered instruction (LUI upper immediate or sign-extended I-immediate)
  always_comb begin
    imm_s = '0;
    if (dec_s.is_lui) begin
      imm_s = WIDTH'({bus.instr[31:12], 12'h000});
    end else begin
      imm_s = WIDTH'($signed(bus.instr[31:20]));
    end
  end

  // Read addresses bypass the latch in the accept cycle so the synchronous
  // register file delivers operand data during READ.
  always_comb begin
    rs1_addr_s = rs1_addr_r;
    rs2_addr_s = rs2_addr_r;
    if (accept_s) begin
      rs1_addr_s = bus.instr[19:15];
      rs2_addr_s = bus.instr[24:20];
    end else begin
      rs1_addr_s = rs1_addr_r;
      rs2_addr_s = rs2_addr_r;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE: begin
        if (bus.instr_valid) begin
          state_next = dec_s.legal ? READ : ILL;
        end else begin
          state_next = IDLE;
        end
      end
      READ:  state_next = ISSUE;
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (bus.alu_valid) begin
          state_next = WB;
        end else begin
          state_next = WAIT;
        end
      end
      WB:      state_next = IDLE;
      ILL:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs and per-instruction context, all timed off the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_ready_r <= 1'b1;
      rs1_addr_r    <= 5'd0;
      rs2_addr_r    <= 5'd0;
      rd_r          <= 5'd0;
      op_r          <= 5'd0;
      use_rs2_r     <= 1'b0;
      is_lui_r      <= 1'b0;
      imm_r         <= '0;
      alu_en_r      <= 1'b0;
      alu_op_r      <= 5'd0;
      alu_a_r       <= '0;
      alu_b_r       <= '0;
      wb_en_r       <= 1'b0;
      wb_addr_r     <= 5'd0;
      wb_data_r     <= '0;
      illegal_r     <= 1'b0;
    end else begin
      instr_ready_r <= (state_next == IDLE);
      alu_en_r      <= (state_next == ISSUE);
      illegal_r     <= (state_next == ILL);
      wb_en_r       <= (state_next == WB) && (rd_r != 5'd0);
      if (accept_s) begin
        rs1_addr_r <= bus.instr[19:15];
        rs2_addr_r <= bus.instr[24:20];
        rd_r       <= bus.instr[11:7];
        op_r       <= dec_s.op;
        use_rs2_r  <= dec_s.use_rs2;
        is_lui_r   <= dec_s.is_lui;
        imm_r      <= imm_s;
      end
      if (state_r == READ) begin
        alu_op_r <= op_r;
        alu_a_r  <= is_lui_r ? '0 : bus.rs1_data;
        alu_b_r  <= use_rs2_r ? bus.rs2_data : imm_r;
      end
      if ((state_r == WAIT) && bus.alu_valid) begin
        wb_data_r <= bus.alu_result;
        wb_addr_r <= rd_r;
      end
    end
  end

  assign bus.instr_ready = instr_ready_r;
  assign bus.rs1_addr    = rs1_addr_s;
  assign bus.rs2_addr    = rs2_addr_s;
  assign bus.alu_en      = alu_en_r;
  assign bus.alu_op      = alu_op_r;
  assign bus.alu_a       = alu_a_r;
  assign bus.alu_b       = alu_b_r;
  assign bus.wb_en       = wb_en_r;
  assign bus.wb_addr     = wb_addr_r;
  assign bus.wb_data     = wb_data_r;
  assign bus.illegal     = illegal_r;

endmodule
